// File: rtl/solver_pkg.sv
// Shared types and sizes for the job-assignment solver and its cost-table loader.
package solver_pkg;

  localparam int N_W       = 8;
  localparam int N_J       = 8;
  localparam int COST_W    = 7;
  localparam int LB_W      = 10;
  localparam int TBL_DEPTH = N_W * N_J;
  localparam int ADDR_W    = 6;

  localparam logic [COST_W-1:0] COST_MAX = 7'd127;

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } loader_state_t;

  function automatic logic [COST_W-1:0] cost_min(input logic [COST_W-1:0] a,
                                                 input logic [COST_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cost_regfile.sv
// 64-entry cost storage: one write port, one registered read port with clear.
module cost_regfile
  import solver_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic              re,
  input  logic              rclr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [COST_W-1:0] rdata
);

  logic [COST_W-1:0] mem [TBL_DEPTH];

  // Contents are don't-care after reset, so the array itself carries no reset.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      rdata <= '0;
    else if (rclr) rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/cost_table_loader.sv
// Loads an 8x8 cost matrix from a valid/ready stream, serves W/J reads and
// accumulates the sum of row minima as a lower bound.
//
// state | meaning
// LOAD  | accepting beats, reads return 0
// DONE  | table complete, reads serviced, stream stalled
module cost_table_loader
  import solver_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [COST_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  output logic              tbl_ready,
  output logic [LB_W-1:0]   lower_bound
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [COST_W-1:0] rowmin_q;
  logic [LB_W-1:0]   acc_q;
  logic [COST_W-1:0] rowmin_next;
  logic              accept;
  logic              rd_en;
  logic              rd_clr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= LOAD;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    tbl_ready = 1'b0;
    accept    = 1'b0;
    rd_en     = 1'b0;
    rd_clr    = 1'b1;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid && !reload;
        if (accept && cnt_q == 6'd63) state_d = DONE;
      end
      DONE: begin
        tbl_ready = 1'b1;
        rd_en     = !reload;
        rd_clr    = reload;
      end
      default: state_d = LOAD;
    endcase
    if (reload) state_d = LOAD;
  end

  assign rowmin_next = cost_min(rowmin_q, in_data);

  // The last beat of each row folds its minimum into the accumulator directly.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q    <= '0;
      rowmin_q <= COST_MAX;
      acc_q    <= '0;
    end else if (reload) begin
      cnt_q    <= '0;
      rowmin_q <= COST_MAX;
      acc_q    <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 6'd1;
      if (cnt_q[2:0] == 3'd7) begin
        acc_q    <= acc_q + LB_W'(rowmin_next);
        rowmin_q <= COST_MAX;
      end else begin
        rowmin_q <= rowmin_next;
      end
    end
  end

  assign lower_bound = tbl_ready ? acc_q : '0;

  cost_regfile u_regfile (
    .CLK   (CLK),
    .RST   (RST),
    .we    (accept),
    .waddr (cnt_q),
    .wdata (in_data),
    .re    (rd_en),
    .rclr  (rd_clr),
    .raddr ({W, J}),
    .rdata (Cost)
  );

endmodule

// File: tb/tb_cost_table_loader.sv
// Directed bench for cost_table_loader: table/lower-bound model checked every cycle
// plus hand-computed literal expectations.
module tb_cost_table_loader;
  import solver_pkg::*;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              in_valid = 1'b0;
  logic [COST_W-1:0] in_data = '0;
  logic              reload = 1'b0;
  logic [2:0]        W = '0;
  logic [2:0]        J = '0;
  logic              in_ready;
  logic              tbl_ready;
  logic [COST_W-1:0] Cost;
  logic [LB_W-1:0]   lower_bound;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  cost_table_loader dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .reload      (reload),
    .W           (W),
    .J           (J),
    .Cost        (Cost),
    .tbl_ready   (tbl_ready),
    .lower_bound (lower_bound)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the table as loaded so far, how many beats have been taken, and the
  // read result expected after the current edge.
  logic [COST_W-1:0] tbl_m [64];
  int                cnt_m  = 0;
  bit                done_m = 1'b0;
  logic [COST_W-1:0] cost_m = '0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_m  <= 0;
      done_m <= 1'b0;
      cost_m <= '0;
    end else if (reload) begin
      cnt_m  <= 0;
      done_m <= 1'b0;
      cost_m <= '0;
    end else if (!done_m) begin
      cost_m <= '0;
      if (in_valid) begin
        tbl_m[cnt_m] <= in_data;
        cnt_m        <= cnt_m + 1;
        if (cnt_m == 63) done_m <= 1'b1;
      end
    end else begin
      cost_m <= tbl_m[{W, J}];
    end
  end

  function automatic int lb_m();
    int s = 0;
    for (int r = 0; r < 8; r++) begin
      int m = 127;
      for (int c = 0; c < 8; c++)
        if (int'(tbl_m[r*8+c]) < m) m = int'(tbl_m[r*8+c]);
      s += m;
    end
    return s;
  endfunction

  always @(negedge CLK) begin
    if (chk_en && RST) begin
      chk("in_ready", 32'(in_ready), 32'(!done_m));
      chk("tbl_ready", 32'(tbl_ready), 32'(done_m));
      chk("lower_bound", 32'(lower_bound), done_m ? 32'(lb_m()) : 32'd0);
      chk("cost", 32'(Cost), 32'(cost_m));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [COST_W-1:0] beat_val(input int kind, input int k);
    case (kind)
      0:       return 7'(k);
      1:       return 7'd127;
      2:       return 7'd0;
      3:       return 7'(5 + (((k >> 3) + (k & 7)) % 8));
      4:       return 7'd100;
      default: return 7'd0;
    endcase
  endfunction

  task automatic load(input int kind, input int duty, input int stop_at);
    int k = 0;
    int budget = 0;
    while (k < stop_at && budget < 3000) begin
      in_valid = ($urandom_range(0, 99) < duty);
      in_data  = beat_val(kind, k);
      tick();
      if (in_valid) k++;
      budget++;
    end
    in_valid = 1'b0;
    if (k < stop_at) chk("load_timeout", 32'(k), 32'(stop_at));
  endtask

  task automatic read_lit(input int w, input int j, input int exp);
    W = 3'(w);
    J = 3'(j);
    tick();
    @(negedge CLK);
    chk("cost_lit", 32'(Cost), 32'(exp));
  endtask

  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++) begin
      W = 3'($urandom_range(0, 7));
      J = 3'($urandom_range(0, 7));
      tick();
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_tbl_ready"}, 32'(tbl_ready), 32'd0);
    chk({tag, "_cost"}, 32'(Cost), 32'd0);
    chk({tag, "_lb"}, 32'(lower_bound), 32'd0);
  endtask

  task automatic async_reset(input string tag);
    #1 RST = 1'b0;
    #1 chk_reset_vals(tag);
    tick();
    RST = 1'b1;
  endtask

  initial begin
    repeat (3) tick();
    @(negedge CLK);
    chk_reset_vals("reset");
    tick();
    RST    = 1'b1;
    chk_en = 1'b1;

    // Ramp table, no gaps
    load(0, 100, 64);
    @(negedge CLK);
    chk("t1_tbl_ready", 32'(tbl_ready), 32'd1);
    chk("t1_lb", 32'(lower_bound), 32'd224);
    read_lit(3, 5, 29);
    read_lit(7, 7, 63);
    rand_reads(30);

    // All-max and all-zero tables
    pulse_reload();
    load(1, 100, 64);
    @(negedge CLK);
    chk("t2_lb_max", 32'(lower_bound), 32'd1016);
    rand_reads(20);
    pulse_reload();
    load(2, 100, 64);
    @(negedge CLK);
    chk("t2_lb_zero", 32'(lower_bound), 32'd0);
    rand_reads(20);

    // Ramp table with 30% valid duty
    pulse_reload();
    load(0, 30, 64);
    @(negedge CLK);
    chk("t3_lb", 32'(lower_bound), 32'd224);
    read_lit(3, 5, 29);
    rand_reads(30);

    // Reload collides with beat 20 of a first load
    pulse_reload();
    load(4, 100, 20);
    in_valid = 1'b1;
    in_data  = 7'd100;
    reload   = 1'b1;
    tick();
    reload   = 1'b0;
    in_valid = 1'b0;
    load(3, 100, 64);
    @(negedge CLK);
    chk("t4_lb", 32'(lower_bound), 32'd40);
    read_lit(7, 1, 5);
    read_lit(0, 0, 5);

    // Stream ignored in DONE
    in_valid = 1'b1;
    in_data  = 7'd0;
    repeat (10) tick();
    in_valid = 1'b0;
    @(negedge CLK);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_lb", 32'(lower_bound), 32'd40);
    read_lit(2, 6, 5);
    read_lit(2, 5, 12);
    rand_reads(20);

    // Asynchronous reset mid-load, then mid-read
    pulse_reload();
    load(0, 100, 40);
    async_reset("rst_load");
    load(0, 100, 64);
    @(negedge CLK);
    chk("t6_lb", 32'(lower_bound), 32'd224);
    read_lit(3, 5, 29);
    tick();
    async_reset("rst_read");
    load(1, 100, 64);
    @(negedge CLK);
    chk("t6_lb_max", 32'(lower_bound), 32'd1016);
    read_lit(0, 0, 127);
    rand_reads(10);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
